// File: rtl/if_fetch_queue.sv
// Instruction fetch queue between the PC/IM fetch stage and ID.
// Show-ahead FIFO of {PC, Instr, misalign} with full-stall and redirect flush.
module if_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          PTR_W    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic [31:0]      PC,
    input  logic [31:0]      Instr,
    input  logic             fetch_valid,
    output logic             Nop,
    input  logic             id_ready,
    output logic             id_valid,
    output logic [31:0]      Instr_ID,
    output logic [31:0]      PC_IFID,
    output logic [31:0]      PC4_IFID,
    output logic             misalign,
    input  logic             flush,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    logic [31:0]      pc_mem_r    [DEPTH];
    logic [31:0]      instr_mem_r [DEPTH];
    logic             mis_mem_r   [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W:0]   count_r;

    logic             full_s;
    logic             valid_s;
    logic             push_s;
    logic             pop_s;

    function automatic logic pc_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    assign full_s  = (count_r == DEPTH_C);
    assign valid_s = (count_r != {(PTR_W+1){1'b0}});
    // A full queue refuses the push even if a pop frees a slot this cycle.
    assign push_s  = fetch_valid && !full_s;
    assign pop_s   = valid_s && id_ready;

    // Pointer, occupancy and entry storage update.
    always_ff @(posedge Clk) begin
        if (rst) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]    <= 32'h0000_0000;
                instr_mem_r[i] <= 32'h0000_0000;
                mis_mem_r[i]   <= 1'b0;
            end
        end else if (flush) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else begin
            if (push_s) begin
                pc_mem_r[wr_ptr_r]    <= PC;
                instr_mem_r[wr_ptr_r] <= Instr;
                mis_mem_r[wr_ptr_r]   <= pc_misaligned(PC);
                wr_ptr_r              <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Head entry presentation; an empty queue shows a NOP at RESET_PC.
    always_comb begin
        Instr_ID = 32'h0000_0000;
        PC_IFID  = RESET_PC;
        misalign = 1'b0;
        if (valid_s) begin
            Instr_ID = instr_mem_r[rd_ptr_r];
            PC_IFID  = pc_mem_r[rd_ptr_r];
            misalign = mis_mem_r[rd_ptr_r];
        end else begin
            Instr_ID = 32'h0000_0000;
            PC_IFID  = RESET_PC;
            misalign = 1'b0;
        end
    end

    assign PC4_IFID = PC_IFID + 32'd4;
    assign id_valid = valid_s;
    assign Nop      = full_s;
    assign count    = count_r;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed self-checking bench for if_fetch_queue: fill, drain, stream,
// flush priority, full-with-pop, address edge values and mid-run reset.
module tb_if_fetch_queue;

    logic        Clk = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic [31:0] Instr;
    logic        fetch_valid;
    logic        Nop;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] Instr_ID;
    logic [31:0] PC_IFID;
    logic [31:0] PC4_IFID;
    logic        misalign;
    logic        flush;
    logic [2:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    if_fetch_queue #(.DEPTH(4), .PTR_W(2), .RESET_PC(32'h0000_3000)) dut (
        .Clk(Clk), .rst(rst), .PC(PC), .Instr(Instr), .fetch_valid(fetch_valid),
        .Nop(Nop), .id_ready(id_ready), .id_valid(id_valid), .Instr_ID(Instr_ID),
        .PC_IFID(PC_IFID), .PC4_IFID(PC4_IFID), .misalign(misalign),
        .flush(flush), .count(count)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic present(input logic [31:0] addr);
        fetch_valid = 1'b1;
        PC          = addr;
        Instr       = addr ^ 32'hA5A5_0000;
    endtask

    // Occupancy must stay within 0..DEPTH at all times.
    always @(negedge Clk) begin
        if (rst === 1'b0) check_eq("count_bound", {31'd0, (count <= 3'd4)}, 32'd1);
    end

    initial begin
        rst = 1'b1; PC = 32'h0; Instr = 32'h0; fetch_valid = 1'b0;
        id_ready = 1'b0; flush = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_eq("rst_valid", {31'd0, id_valid}, 32'd0);
        check_eq("rst_nop",   {31'd0, Nop}, 32'd0);
        check_eq("rst_count", {29'd0, count}, 32'd0);
        check_eq("rst_instr", Instr_ID, 32'h0000_0000);
        check_eq("rst_pc",    PC_IFID, 32'h0000_3000);
        check_eq("rst_pc4",   PC4_IFID, 32'h0000_3004);

        // Fill: five pairs offered, fifth refused while full
        for (int i = 0; i < 5; i++) begin
            present(32'h0000_3000 + 32'(4 * i));
            tick();
            check_eq("fill_count", {29'd0, count}, (i < 4) ? 32'(i + 1) : 32'd4);
            check_eq("fill_nop", {31'd0, Nop}, (i >= 3) ? 32'd1 : 32'd0);
        end
        check_eq("full_head_pc",  PC_IFID, 32'h0000_3000);
        check_eq("full_head_pc4", PC4_IFID, 32'h0000_3004);
        check_eq("full_head_ins", Instr_ID, 32'hA5A5_3000);

        // Drain in order
        fetch_valid = 1'b0; id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("drain_pc",  PC_IFID, 32'h0000_3000 + 32'(4 * i));
            check_eq("drain_ins", Instr_ID, (32'h0000_3000 + 32'(4 * i)) ^ 32'hA5A5_0000);
            tick();
        end
        check_eq("drain_valid", {31'd0, id_valid}, 32'd0);
        check_eq("drain_instr", Instr_ID, 32'h0);
        check_eq("drain_pc_e",  PC_IFID, 32'h0000_3000);
        check_eq("drain_count", {29'd0, count}, 32'd0);

        // Streaming: one-cycle latency, then steady occupancy of one
        present(32'h0000_5000);
        check_eq("nobypass_valid", {31'd0, id_valid}, 32'd0);
        tick();
        check_eq("stream_first", PC_IFID, 32'h0000_5000);
        for (int i = 1; i < 6; i++) begin
            present(32'h0000_5000 + 32'(4 * i));
            check_eq("stream_head", PC_IFID, 32'h0000_5000 + 32'(4 * (i - 1)));
            tick();
            check_eq("stream_count", {29'd0, count}, 32'd1);
            check_eq("stream_nop", {31'd0, Nop}, 32'd0);
        end
        fetch_valid = 1'b0;
        tick();
        check_eq("stream_end", {29'd0, count}, 32'd0);

        // Flush beats push and pop
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            present(32'h0000_6000 + 32'(4 * i));
            tick();
        end
        check_eq("pre_flush_cnt", {29'd0, count}, 32'd3);
        present(32'h0000_4000); id_ready = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush_count", {29'd0, count}, 32'd0);
        check_eq("flush_valid", {31'd0, id_valid}, 32'd0);
        check_eq("flush_nop", {31'd0, Nop}, 32'd0);
        present(32'h0000_4000); id_ready = 1'b0;
        tick();
        fetch_valid = 1'b0;
        check_eq("post_flush_pc", PC_IFID, 32'h0000_4000);
        check_eq("post_flush_cnt", {29'd0, count}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // Full with simultaneous pop: push refused, re-presented later
        for (int i = 0; i < 4; i++) begin
            present(32'h0000_7000 + 32'(4 * i));
            tick();
        end
        check_eq("fp_nop_full", {31'd0, Nop}, 32'd1);
        present(32'h0000_7010); id_ready = 1'b1;
        tick();
        check_eq("fp_count", {29'd0, count}, 32'd3);
        check_eq("fp_nop", {31'd0, Nop}, 32'd0);
        check_eq("fp_head", PC_IFID, 32'h0000_7004);
        id_ready = 1'b0;
        tick();
        check_eq("fp_repush", {29'd0, count}, 32'd4);
        fetch_valid = 1'b0; id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("fp_order", PC_IFID, 32'h0000_7004 + 32'(4 * i));
            tick();
        end
        check_eq("fp_empty", {29'd0, count}, 32'd0);

        // Address edge values
        id_ready = 1'b0;
        fetch_valid = 1'b1; PC = 32'hFFFF_FFFC; Instr = 32'h1111_1111;
        tick();
        fetch_valid = 1'b1; PC = 32'h0000_3002; Instr = 32'h2222_2222;
        check_eq("wrap_pc4", PC4_IFID, 32'h0000_0000);
        check_eq("wrap_mis", {31'd0, misalign}, 32'd0);
        tick();
        fetch_valid = 1'b0; id_ready = 1'b1;
        tick();
        check_eq("mis_flag",  {31'd0, misalign}, 32'd1);
        check_eq("mis_instr", Instr_ID, 32'h2222_2222);
        check_eq("mis_pc4",   PC4_IFID, 32'h0000_3006);
        tick();
        check_eq("edge_empty", {29'd0, count}, 32'd0);
        check_eq("edge_mis_e", {31'd0, misalign}, 32'd0);

        // Reset mid-operation drops entries
        id_ready = 1'b0;
        present(32'h0000_8000); tick();
        present(32'h0000_8004); tick();
        fetch_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mrst_count", {29'd0, count}, 32'd0);
        check_eq("mrst_instr", Instr_ID, 32'h0);
        check_eq("mrst_pc",    PC_IFID, 32'h0000_3000);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction fetch queue between the PC/instruction-memory fetch stage and the ID stage.
- Captures each fetched {PC, instruction} pair into a small FIFO and presents the oldest entry to ID with valid/ready handshaking.
- Drives the Nop stall back to the PC stage when the queue is full.
- Discards all queued entries when ID resolves a redirect (branch, j/jal, jr).

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- PTR_W, 2, pointer width, equal to log2(DEPTH).
- RESET_PC, 32'h0000_3000, value reported on PC_IFID while the queue is empty.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- PC  input  32  address of the instruction presented this cycle by the PC stage.
- Instr  input  32  instruction word read from instruction memory at PC.
- fetch_valid  input  1  PC/Instr pair is valid this cycle.
- Nop  output  1  stall request to the PC stage; the PC holds its value while this is 1.
- id_ready  input  1  ID stage accepts the head entry this cycle.
- id_valid  output  1  head entry valid.
- Instr_ID  output  32  head instruction word.
- PC_IFID  output  32  head instruction address.
- PC4_IFID  output  32  head address plus 4; used as the jal link value.
- misalign  output  1  head entry PC[1:0] != 0.
- flush  input  1  redirect taken in ID; discard all entries.
- count  output  PTR_W+1  number of occupied entries.

Behaviour:
- Storage: DEPTH entries, each holding {PC, Instr, misalign bit}. Read pointer, write pointer and count are registered. Pointers wrap modulo DEPTH.
- Show-ahead output: id_valid = (count != 0). Instr_ID, PC_IFID and misalign are driven combinationally from the entry at the read pointer.
- Empty queue outputs:
  - Instr_ID = 32'h0000_0000 (sll $0 NOP).
  - PC_IFID = RESET_PC.
  - PC4_IFID = RESET_PC + 4.
  - misalign = 0.
- PC4_IFID = PC_IFID + 32'd4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- Nop = (count == DEPTH), combinational from registered count.
- push = fetch_valid && !Nop.
  - A push is refused when the queue is full, even if a pop happens in the same cycle.
  - The PC stage re-presents the refused pair once Nop deasserts.
- pop = id_valid && id_ready. id_ready while empty has no effect.
- Simultaneous push and pop (queue not full): both take effect, count unchanged, both pointers advance.
- Latency: an entry pushed in cycle N appears on the outputs in cycle N+1 when the queue was empty. There is no combinational bypass from fetch inputs to ID outputs.
- flush has priority over push and pop in the same cycle.
  - Next edge: pointers = 0, count = 0. The incoming pair and any pop that cycle are discarded.
  - The cycle after the flush: id_valid = 0 and Nop = 0.
- rst has priority over everything.
  - Next edge: pointers = 0, count = 0, all entry storage cleared to 0.
  - Outputs after reset: id_valid = 0, Nop = 0, count = 0, Instr_ID = 0, PC_IFID = RESET_PC.
  - Reset mid-operation drops all entries identically to flush.
- misalign is stored per entry. The queue never drops or alters a misaligned entry; ID raises the exception.
- The queue is pure data storage with no instruction decoding.
- Entry contents never change between push and pop.
- count never exceeds DEPTH and never underflows; the verification bench asserts both.

Test Plan:
- Reset then fill: rst for 2 cycles; drive fetch_valid=1, id_ready=0, PC=3000, 3004, 3008, 300C, 3010 with Instr = PC ^ 32'hA5A5_0000 → count reaches 4. Nop=1 from the cycle after the 4th push. The 3010 pair is refused. Head stays PC_IFID=3000, PC4_IFID=3004.
- Drain in order: continuing from full, id_ready=1, fetch_valid=0 → four pops, outputs PC 3000, 3004, 3008, 300C in sequence. Then id_valid=0, Instr_ID=0, PC_IFID=3000 (RESET_PC), count=0.
- Streaming: fetch_valid=1 and id_ready=1 every cycle from empty with PC incrementing by 4 → after one cycle of latency, count holds at 1. One instruction per cycle reaches ID. Nop is never asserted.
- Flush priority: with count=3, assert flush together with fetch_valid=1 (PC=4000) and id_ready=1 → next cycle count=0, id_valid=0, Nop=0. The following push of PC=4000 appears at the head one cycle later.
- Full with pop: count=4, id_ready=1 and fetch_valid=1 in the same cycle → count becomes 3. The new pair is refused. Nop=0 next cycle and the re-presented pair is accepted.
- Edge values: push PC=32'hFFFF_FFFC, then PC=32'h0000_3002 → first head shows PC4_IFID=0, misalign=0. After the pop, the second head shows misalign=1 with its Instr intact.
